// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader; holds the CPU while words are written.
// Optional trailing XOR checksum byte is enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
`else
  localparam state_t TAIL = DONE;
`endif

  state_t            state;
  state_t            nxt;
  logic [1:0]        bcnt;
  logic [15:0]       len;
  logic [15:0]       cnt;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       sh;
  logic              xfer;
  logic              go;
  logic              rdy_nxt;
  logic              hold_nxt;
  logic [15:0]       len_nxt;
  logic [31:0]       word_nxt;

  assign xfer     = in_valid & in_ready;
  assign go       = start & ((state == IDLE) | (state == DONE));
  assign len_nxt  = {in_data, len[15:8]};
  assign word_nxt = {in_data, sh[31:8]};

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = LEN;
      LEN: begin
        if (xfer && bcnt == 2'd1)
          nxt = (len_nxt == 16'd0) ? TAIL : DATA;
      end
      DATA:  if (xfer && bcnt == 2'd3) nxt = WRITE;
      WRITE: nxt = (cnt + 16'd1 == len) ? TAIL : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM:  if (xfer) nxt = DONE;
`endif
      DONE:  if (start) nxt = LEN;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy_nxt  = (nxt == LEN) | (nxt == DATA);
    hold_nxt = rdy_nxt | (nxt == WRITE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    rdy_nxt  = rdy_nxt | (nxt == CSUM);
    hold_nxt = hold_nxt | (nxt == CSUM);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      bcnt     <= '0;
      len      <= '0;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
    end else begin
      state    <= nxt;
      in_ready <= rdy_nxt;
      cpu_hold <= hold_nxt;
      done     <= (nxt == DONE);
      wr_en    <= (nxt == WRITE);
      if (go) begin
        bcnt <= '0;
        cnt  <= '0;
        idx  <= '0;
      end
      if (state == LEN && xfer) begin
        len  <= len_nxt;
        bcnt <= (bcnt == 2'd1) ? 2'd0 : bcnt + 2'd1;
      end
      if (state == DATA && xfer) begin
        sh   <= word_nxt;
        bcnt <= bcnt + 2'd1;
        // Capture once so wr_addr/wr_data stay put between writes.
        if (bcnt == 2'd3) begin
          wr_data <= word_nxt;
          wr_addr <= idx;
        end
      end
      if (state == WRITE) begin
        idx <= idx + ADDR_W'(1);
        cnt <= cnt + 16'd1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum  <= '0;
      error <= 1'b0;
    end else begin
      if (go) begin
        csum  <= '0;
        error <= 1'b0;
      end
      if (state == DATA && xfer)
        csum <= csum ^ in_data;
      if (state == CSUM && xfer)
        error <= (in_data != csum);
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader (ADDR_W=8 and ADDR_W=2 copies).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        rdy8, we8, hold8, done8, err8;
  logic [7:0]  a8;
  logic [31:0] d8;
  logic        rdy2, we2, hold2, done2, err2;
  logic [1:0]  a2;
  logic [31:0] d2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];
  bit   we8_prev = 0;
  bit   we2_prev = 0;
  bit   ph = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy8),
    .wr_en(we8), .wr_addr(a8), .wr_data(d8),
    .cpu_hold(hold8), .done(done8), .error(err8)
  );

  imem_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy2),
    .wr_en(we2), .wr_addr(a2), .wr_data(d2),
    .cpu_hold(hold2), .done(done2), .error(err2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitors: pop expected writes whenever a DUT strobes wr_en.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (we8) begin
        chk("w8_rdy_low", {31'd0, rdy8}, 0);
        chk("w8_pulse", {31'd0, we8_prev}, 0);
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL w8_extra: got write %h@%h expected none", d8, a8);
        end else begin
          e = q8.pop_front();
          if (a8 !== e.addr[7:0] || d8 !== e.data) begin
            errors++;
            $display("FAIL w8: got %h@%h expected %h@%h",
                     d8, a8, e.data, e.addr[7:0]);
          end
        end
      end
      we8_prev = we8;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (we2) begin
        chk("w2_rdy_low", {31'd0, rdy2}, 0);
        chk("w2_pulse", {31'd0, we2_prev}, 0);
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL w2_extra: got write %h@%h expected none", d2, a2);
        end else begin
          e = q2.pop_front();
          if (a2 !== e.addr[1:0] || d2 !== e.data) begin
            errors++;
            $display("FAIL w2: got %h@%h expected %h@%h",
                     d2, a2, e.data, e.addr[1:0]);
          end
        end
      end
      we2_prev = we2;
    end
  end

  task automatic expect_word(input int i, input logic [31:0] w);
    exp_t e;
    e.data = w;
    e.addr = i % 256;
    q8.push_back(e);
    e.addr = i % 4;
    q2.push_back(e);
  endtask

  // mode 0: no stalls, 1: in_valid low every other cycle, 2: random
  task automatic send_byte(input logic [7:0] b, input int mode);
    int g = 0;
    forever begin
      @(negedge clk);
      ph = !ph;
      g++;
      if (g > 100) begin
        errors++;
        $display("FAIL send_timeout: got no accept expected in_ready");
        in_valid = 1'b0;
        return;
      end
      if ((mode == 1 && ph) || (mode == 2 && $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        if (rdy8) begin
          @(posedge clk);
          return;
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load(input logic [31:0] w[$], input int mode,
                      input bit smid, input bit bad);
    logic [7:0]  x = 8'h00;
    logic [7:0]  b;
    logic [15:0] n;
    int t = 0;
    n = 16'(w.size());
    pulse_start();
    chk("hold_on", {31'd0, hold8}, 1);
    chk("done_clr", {31'd0, done8}, 0);
    foreach (w[i]) expect_word(i, w[i]);
    send_byte(n[7:0], mode);
    send_byte(n[15:8], mode);
    foreach (w[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = w[i][8*k +: 8];
        x = x ^ b;
        send_byte(b, mode);
        if (smid && i == 1 && k == 1) pulse_start();
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad ? ~x : x, mode);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    while (!done8 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("done8", {31'd0, done8}, 1);
    chk("done2", {31'd0, done2}, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("error8", {31'd0, err8}, {31'd0, bad});
`else
    chk("error8", {31'd0, err8}, 0);
`endif
    chk("hold_off", {31'd0, hold8}, 0);
    chk("rdy_done", {31'd0, rdy8}, 0);
    chk("q8_empty", q8.size(), 0);
    chk("q2_empty", q2.size(), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_rdy", {31'd0, rdy8}, 0);
    chk("rst_we", {31'd0, we8}, 0);
    chk("rst_addr", {24'd0, a8}, 0);
    chk("rst_data", d8, 0);
    chk("rst_hold", {31'd0, hold8}, 0);
    chk("rst_done", {31'd0, done8}, 0);
    chk("rst_err", {31'd0, err8}, 0);
    chk("rst_hold2", {31'd0, hold2}, 0);
  endtask

  logic [31:0] demo[$] = '{32'h00500093, 32'h00300113, 32'h002081b3,
                           32'h00a00213, 32'h004182b3};
  logic [31:0] none[$];
  logic [31:0] one[$] = '{32'h00500093};
  logic [31:0] rw[$];

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;

    load(demo, 0, 0, 0);
    load(demo, 1, 0, 0);
    load(none, 0, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    load(one, 0, 0, 0);
    load(one, 0, 0, 1);
    load(one, 2, 0, 0);
`else
    load(one, 2, 0, 0);
`endif

    // Abort mid-word: first word lands, second is discarded.
    pulse_start();
    expect_word(0, demo[0]);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++) send_byte(demo[0][8*k +: 8], 0);
    send_byte(demo[1][7:0], 0);
    send_byte(demo[1][15:8], 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    chk("rst_q8", q8.size(), 0);
    rst_n = 1'b1;
    load(demo, 0, 0, 0);

    load(demo, 0, 1, 0);

    for (int r = 0; r < 6; r++) begin
      rw.delete();
      for (int i = 0; i < $urandom_range(1, 7); i++)
        rw.push_back($urandom);
      load(rw, $urandom_range(0, 2), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
